fixed_point_div_arbiter: RTL and testbench
==========================================

// Module: fixed_point_div_arbiter
// PURPOSE
//  Shares one iterative signed fixed-point long-division unit among NUM_REQ requesters.
//  Round-robin grant; issues start, waits for done, returns the quotient to the granted requester.
//  Handles divide-by-zero locally, without using the divider.
//  Sits between DSP filter stages (normalisation, gain) and the single shared divider instance.
// PARAMETERS
//  NUM_REQ        4   number of requesters (>=2)
//  DATA_W         8   operand/quotient width, two's complement
//  FRAC_BITS      4   fractional bits; informational only, passed through to the divider
//  TIMEOUT_CYCLES 64  watchdog limit in WAIT; used only with DIV_TIMEOUT_EN
// PORTS
//  i_clk           in   1                 clock, all logic on rising edge
//  i_reset_n       in   1                 asynchronous, active-low reset
//  i_req_valid     in   NUM_REQ           per-requester request valid
//  i_req_dividend  in   NUM_REQ*DATA_W    packed dividends; slice g = requester g
//  i_req_divisor   in   NUM_REQ*DATA_W    packed divisors
//  o_req_ready     out  NUM_REQ           one-hot accept; a transfer occurs when valid&ready
//  o_div_start     out  1                 one-cycle start pulse to the divider
//  o_div_dividend  out  DATA_W            latched dividend, stable from start to done
//  o_div_divisor   out  DATA_W            latched divisor
//  i_div_done      in   1                 divider result valid (single-cycle pulse)
//  i_div_quotient  in   DATA_W            divider result
//  o_rsp_valid     out  1                 response valid
//  o_rsp_id        out  $clog2(NUM_REQ)   granted requester index
//  o_rsp_quotient  out  DATA_W            result
//  o_rsp_div0      out  1                 divisor was zero
//  o_rsp_timeout   out  1                 watchdog fired; tied 0 without DIV_TIMEOUT_EN
//  i_rsp_ready     in   1                 consumer accepts response
// BEHAVIOUR
//  Reset:
//   - state=IDLE, rr_ptr=0; all outputs and latched operands 0.
//   - Reset mid-operation aborts silently; no response is emitted.
//   - The divider shares i_reset_n.
//  FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE:
//   - IDLE: o_req_ready is combinational. It is one-hot on the first valid requester, searching
//     from rr_ptr upward with wrap-around, and is 0 when no request is valid. On transfer, latch
//     operands and id.
//     - Divisor == 0: go to RESP, div0=1. Quotient saturates: dividend>0 -> 0x7F..F,
//       dividend<0 -> 0x80..0, dividend==0 -> 0.
//     - Divisor != 0: go to ISSUE.
//   - ISSUE: o_div_start=1 for exactly this cycle; go to WAIT.
//   - WAIT: on i_div_done, register i_div_quotient; go to RESP.
//     i_div_done in any other state is ignored.
//   - RESP: o_rsp_valid stays high and the response fields stay stable until i_rsp_ready.
//     On that handshake: rr_ptr = (id+1) mod NUM_REQ, go to IDLE.
//  Latency:
//   - Normal path: accept cycle N, start at N+1, response registered the cycle after done.
//   - Div0 path: o_rsp_valid at N+1.
//  Grants:
//   - No grant is issued outside IDLE. All o_req_ready are 0 in ISSUE, WAIT and RESP.
//   - Back-to-back: the next grant is possible in the cycle after the response handshake.
//   - Requests are never dropped. Non-granted valids must stay asserted.
// CONFIGURATION
//  DIV_TIMEOUT_EN defined:
//   - A counter clears on entry to WAIT.
//   - If TIMEOUT_CYCLES elapse without done: go to RESP, quotient=0, o_rsp_timeout=1.
//   - A late done arriving after the timeout is ignored.
//  DIV_TIMEOUT_EN undefined:
//   - No counter; WAIT persists until done; o_rsp_timeout=0.
// TESTING
//  1 Req2 valid, 0x30/0x20, model done 10 cycles after start with 0x18
//    -> ready[2] 1 cycle, start 1 cycle later, rsp id=2 q=0x18 div0=0.
//  2 All 4 valid continuously, rr_ptr=0
//    -> service order 0,1,2,3,0; no overlapping grants.
//  3 Req1 0xF0/0x00
//    -> no o_div_start; rsp next cycle, q=0x80, div0=1. 0x10/0x00 -> q=0x7F.
//  4 i_rsp_ready low 5 cycles during RESP
//    -> rsp fields stable, o_req_ready all 0; release -> IDLE, next grant next cycle.
//  5 Reset pulse while in WAIT
//    -> outputs 0 immediately, no rsp; after release req0 and req3 valid -> req0 granted.
//  6 DIV_TIMEOUT_EN, TIMEOUT_CYCLES=16, no done
//    -> rsp timeout=1 q=0x00 after 16 WAIT cycles. Macro off -> still WAIT at cycle 100.

Source files
------------

// File: rtl/fixed_point_div_arbiter.sv
// Round-robin arbiter sharing one iterative signed fixed-point divider among NUM_REQ requesters.
// Optional DIV_TIMEOUT_EN adds a WAIT-state watchdog that returns quotient 0 with o_rsp_timeout set.
`default_nettype none

module fixed_point_div_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int FRAC_BITS      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  i_req_dividend,
  input  logic [NUM_REQ*DATA_W-1:0]  i_req_divisor,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic                       o_div_start,
  output logic [DATA_W-1:0]          o_div_dividend,
  output logic [DATA_W-1:0]          o_div_divisor,
  input  logic                       i_div_done,
  input  logic [DATA_W-1:0]          i_div_quotient,
  output logic                       o_rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0] o_rsp_id,
  output logic [DATA_W-1:0]          o_rsp_quotient,
  output logic                       o_rsp_div0,
  output logic                       o_rsp_timeout,
  input  logic                       i_rsp_ready
);

  localparam int ID_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || FRAC_BITS < 0 || FRAC_BITS >= DATA_W || TIMEOUT_CYCLES < 1) begin : g_param_err
    $error("fixed_point_div_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              state_q;
  logic [ID_W-1:0]     rr_ptr_q;
  logic [ID_W-1:0]     id_q;
  logic [DATA_W-1:0]   dividend_q;
  logic [DATA_W-1:0]   divisor_q;
  logic [DATA_W-1:0]   quot_q;
  logic                start_q;
  logic                rsp_valid_q;
  logic                div0_q;

`ifdef DIV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]    wait_cnt_q;
  logic                timeout_q;
`endif

  logic [NUM_REQ-1:0]  w_grant;
  logic [ID_W-1:0]     w_gnt_id;
  logic [DATA_W-1:0]   w_sel_dividend;
  logic [DATA_W-1:0]   w_sel_divisor;
  logic [DATA_W-1:0]   w_sat_quot;

  // Scan from the farthest candidate back to rr_ptr so the nearest valid requester wins.
  always_comb begin
    int idx;
    idx            = 0;
    w_grant        = '0;
    w_gnt_id       = '0;
    w_sel_dividend = '0;
    w_sel_divisor  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (i_req_valid[idx]) begin
        w_grant        = '0;
        w_grant[idx]   = 1'b1;
        w_gnt_id       = ID_W'(idx);
        w_sel_dividend = i_req_dividend[idx*DATA_W +: DATA_W];
        w_sel_divisor  = i_req_divisor[idx*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    w_sat_quot = '0;
    if (w_sel_dividend != '0) begin
      w_sat_quot = w_sel_dividend[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                            : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      quot_q      <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      div0_q      <= 1'b0;
`ifdef DIV_TIMEOUT_EN
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (|w_grant) begin
            id_q       <= w_gnt_id;
            dividend_q <= w_sel_dividend;
            divisor_q  <= w_sel_divisor;
            if (w_sel_divisor == '0) begin
              quot_q      <= w_sat_quot;
              div0_q      <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              start_q <= 1'b1;
              state_q <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
`ifdef DIV_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (i_div_done) begin
            quot_q      <= i_div_quotient;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
`ifdef DIV_TIMEOUT_EN
          else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            quot_q      <= '0;
            timeout_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
`endif
        end
        S_RESP: begin
          if (i_rsp_ready) begin
            rsp_valid_q <= 1'b0;
            div0_q      <= 1'b0;
`ifdef DIV_TIMEOUT_EN
            timeout_q   <= 1'b0;
`endif
            rr_ptr_q    <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready    = (state_q == S_IDLE) ? w_grant : '0;
  assign o_div_start    = start_q;
  assign o_div_dividend = dividend_q;
  assign o_div_divisor  = divisor_q;
  assign o_rsp_valid    = rsp_valid_q;
  assign o_rsp_id       = id_q;
  assign o_rsp_quotient = quot_q;
  assign o_rsp_div0     = div0_q;
`ifdef DIV_TIMEOUT_EN
  assign o_rsp_timeout  = timeout_q;
`else
  assign o_rsp_timeout  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fixed_point_div_arbiter.sv
// Scoreboard bench for fixed_point_div_arbiter: directed scenarios plus randomized traffic
// against a cycle-level reference model and a behavioural fixed-point divider.
`default_nettype none

module tb_fixed_point_div_arbiter;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int F   = 4;
  localparam int TO  = 16;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_dvd, req_dvs;
  logic [N-1:0]   req_ready;
  logic           div_start;
  logic [W-1:0]   div_dvd, div_dvs;
  logic           div_done;
  logic [W-1:0]   div_q;
  logic           rsp_valid;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_q;
  logic           rsp_div0, rsp_to;
  logic           rsp_ready;

  fixed_point_div_arbiter #(.NUM_REQ(N), .DATA_W(W), .FRAC_BITS(F), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_req_valid(req_valid), .i_req_dividend(req_dvd), .i_req_divisor(req_dvs),
    .o_req_ready(req_ready),
    .o_div_start(div_start), .o_div_dividend(div_dvd), .o_div_divisor(div_dvs),
    .i_div_done(div_done), .i_div_quotient(div_q),
    .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_quotient(rsp_q),
    .o_rsp_div0(rsp_div0), .o_rsp_timeout(rsp_to), .i_rsp_ready(rsp_ready)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Signed fixed-point quotient (a << F) / b, truncated, saturated; b == 0 saturates by sign of a.
  function automatic logic [W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb, q;
    sa = $signed(a);
    sb = $signed(b);
    if (sb == 0) return (sa > 0) ? 8'h7F : ((sa < 0) ? 8'h80 : 8'h00);
    q = (sa * (1 << F)) / sb;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return q[W-1:0];
  endfunction

  function automatic int pick(input logic [N-1:0] v, input int r);
    for (int k = 0; k < N; k++) if (v[(r + k) % N]) return (r + k) % N;
    return -1;
  endfunction

  typedef struct {
    logic [IDW-1:0] id;
    logic [W-1:0]   q;
    logic           div0;
    logic           to;
  } exp_t;

  exp_t     sb[$];
  int       order_q[$];
  bit       busy, start_due, waiting, rsp_due, chk_en;
  int       wait_n, rr;
  logic [N-1:0] acc_mask;

  task automatic model_reset();
    busy = 0; start_due = 0; waiting = 0; rsp_due = 0; wait_n = 0; rr = 0;
    acc_mask = '0;
    sb.delete();
  endtask

  // Monitor / scoreboard: checks every cycle at the falling edge, then advances the model.
  always @(negedge clk) begin
    int g;
    logic [N-1:0] exp_rdy;
    bit n_start;
    exp_t e, t;
    if (rst_n && chk_en) begin
      g = busy ? -1 : pick(req_valid, rr);
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", req_ready, exp_rdy);
      chk("div_start", div_start, start_due);
      chk("rsp_valid", rsp_valid, rsp_due);
      if (rsp_valid && rsp_due && sb.size() > 0) begin
        chk("rsp_id", rsp_id, sb[0].id);
        chk("rsp_quotient", rsp_q, sb[0].q);
        chk("rsp_div0", rsp_div0, sb[0].div0);
        chk("rsp_timeout", rsp_to, sb[0].to);
      end
      n_start = 0;
      if (g >= 0) begin
        e.id   = g[IDW-1:0];
        e.q    = ref_div(req_dvd[g*W +: W], req_dvs[g*W +: W]);
        e.div0 = (req_dvs[g*W +: W] == '0);
        e.to   = 1'b0;
        sb.push_back(e);
        order_q.push_back(g);
        acc_mask[g] = 1'b1;
        busy = 1;
        if (e.div0) rsp_due = 1;
        else n_start = 1;
      end
      if (start_due) begin
        waiting = 1;
        wait_n  = 0;
      end else if (waiting) begin
        if (div_done) begin
          waiting = 0;
          rsp_due = 1;
        end else begin
          wait_n++;
`ifdef DIV_TIMEOUT_EN
          if (wait_n == TO) begin
            waiting = 0;
            rsp_due = 1;
            t = sb[0];
            t.q = '0;
            t.to = 1'b1;
            sb[0] = t;
          end
`endif
        end
      end
      start_due = n_start;
      if (g < 0 && rsp_due && rsp_valid && rsp_ready && sb.size() > 0) begin
        rr = (int'(sb[0].id) + 1) % N;
        void'(sb.pop_front());
        rsp_due = 0;
        busy = 0;
      end
    end
  end

  // Behavioural divider: fixed or random latency, plus stray done pulses while idle.
  int   lat_fixed = 0;
  bit   div_mute = 0;
  bit   job;
  int   cnt;
  logic [W-1:0] jq;

  initial begin
    div_done = 1'b0;
    div_q = '0;
    job = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) job = 0;
      else if (div_start) begin
        job = 1;
        cnt = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 12));
        jq  = ref_div(div_dvd, div_dvs);
      end
      @(posedge clk);
      #1;
      div_done = 1'b0;
      if (job && !div_mute && rst_n) begin
        cnt--;
        if (cnt == 0) begin
          div_done = 1'b1;
          div_q = jq;
          job = 0;
        end
      end else if (!job && !div_mute && ($urandom_range(0, 7) == 0)) begin
        div_done = 1'b1;
        div_q = W'($urandom);
      end
    end
  end

  task automatic set_req(input int g, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[g] = 1'b1;
    req_dvd[g*W +: W] = a;
    req_dvs[g*W +: W] = b;
  endtask

  task automatic step(input bit keep);
    @(posedge clk);
    #1;
    for (int g = 0; g < N; g++) begin
      if (acc_mask[g]) begin
        if (keep) set_req(g, W'($urandom), W'($urandom_range(1, 255)));
        else req_valid[g] = 1'b0;
      end
    end
    acc_mask = '0;
  endtask

  task automatic wait_rsp(input string name);
    int n;
    n = 0;
    while (!rsp_valid && n < 100) begin
      step(0);
      n++;
    end
    chk(name, rsp_valid, 1'b1);
  endtask

  task automatic drain(input string name);
    int n;
    rsp_ready = 1'b1;
    n = 0;
    while ((req_valid != '0 || busy) && n < 400) begin
      step(0);
      n++;
    end
    chk(name, (n < 400), 1'b1);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ready"}, req_ready, '0);
    chk({name, "_start"}, div_start, '0);
    chk({name, "_dvd"}, div_dvd, '0);
    chk({name, "_dvs"}, div_dvs, '0);
    chk({name, "_rsp_valid"}, rsp_valid, '0);
    chk({name, "_rsp_id"}, rsp_id, '0);
    chk({name, "_rsp_q"}, rsp_q, '0);
    chk({name, "_div0"}, rsp_div0, '0);
    chk({name, "_to"}, rsp_to, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order[5];
    int n;
    exp_order = '{0, 1, 2, 3, 0};
    req_valid = '0;
    req_dvd = '0;
    req_dvs = '0;
    rsp_ready = 1'b0;
    chk_en = 0;
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    chk_en = 1;

    // All four requesters valid continuously from rr_ptr = 0.
    rsp_ready = 1'b1;
    lat_fixed = 2;
    order_q.delete();
    for (int g = 0; g < N; g++) set_req(g, W'($urandom), W'($urandom_range(1, 255)));
    n = 0;
    while (order_q.size() < 5 && n < 200) begin
      step(1);
      n++;
    end
    req_valid = '0;
    chk("t2_five_grants", (order_q.size() >= 5), 1'b1);
    for (int i = 0; i < 5 && i < order_q.size(); i++) chk("t2_order", order_q[i], exp_order[i]);
    drain("t2_drain");

    // Single request through the divider with a 10-cycle latency.
    lat_fixed = 10;
    set_req(2, 8'h30, 8'h20);
    wait_rsp("t1_rsp");
    chk("t1_id", rsp_id, 2);
    chk("t1_q", rsp_q, 8'h18);
    chk("t1_div0", rsp_div0, 1'b0);
    drain("t1_drain");
    lat_fixed = 0;

    // Divide by zero, negative and positive dividends.
    set_req(1, 8'hF0, 8'h00);
    wait_rsp("t3a_rsp");
    chk("t3a_q", rsp_q, 8'h80);
    chk("t3a_div0", rsp_div0, 1'b1);
    drain("t3a_drain");
    set_req(1, 8'h10, 8'h00);
    wait_rsp("t3b_rsp");
    chk("t3b_q", rsp_q, 8'h7F);
    drain("t3b_drain");

    // Consumer back-pressure for 5 cycles, then next grant right after the handshake.
    rsp_ready = 1'b0;
    set_req(3, 8'h55, 8'h07);
    wait_rsp("t4_rsp");
    set_req(0, 8'h21, 8'h03);
    repeat (5) begin
      step(0);
      chk("t4_hold_valid", rsp_valid, 1'b1);
      chk("t4_hold_ready", req_ready, '0);
    end
    rsp_ready = 1'b1;
    step(0);
    chk("t4_next_grant", req_ready, 4'b0001);
    drain("t4_drain");

    // Divider never answers.
    div_mute = 1;
    set_req(2, 8'h40, 8'h10);
`ifdef DIV_TIMEOUT_EN
    wait_rsp("t6_rsp");
    chk("t6_timeout", rsp_to, 1'b1);
    chk("t6_q", rsp_q, 8'h00);
    drain("t6_drain");
    set_req(0, 8'h12, 8'h34);
    n = 0;
    while (!waiting && n < 20) begin
      step(0);
      n++;
    end
    repeat (3) step(0);
`else
    repeat (100) step(0);
    chk("t6_still_wait", rsp_valid, 1'b0);
`endif

    // Asynchronous reset while the divider is outstanding.
    chk("t5_in_wait", waiting, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("t5_reset");
    model_reset();
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    div_mute = 0;
    rst_n = 1'b1;
    set_req(0, 8'h08, 8'h02);
    set_req(3, 8'h09, 8'h03);
    #1;
    chk("t5_grant0", req_ready, 4'b0001);
    drain("t5_drain");

    // Randomized traffic with random consumer back-pressure.
    for (int c = 0; c < 2500; c++) begin
      step(0);
      for (int g = 0; g < N; g++) begin
        if (!req_valid[g] && $urandom_range(0, 3) == 0)
          set_req(g, W'($urandom), ($urandom_range(0, 5) == 0) ? W'(0) : W'($urandom));
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
    end
    drain("rand_drain");
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
